// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - MSB-first pattern serializer with one-shot/loop modes and programmable bit period
module seq_serializer #(
    parameter int CLK_DIV = 4,
    parameter int PAT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_loop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [5:0]       len,
    output logic             seq_out,
    output logic             bit_valid,
    output logic [5:0]       bit_idx,
    output logic             busy,
    output logic             done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [5:0]    PAT_LEN = 6'(PAT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [PAT_W-1:0] pat_q;
    logic [5:0]       len_q;
    logic             loop_q;

    logic [5:0]  len_eff;
    logic [5:0]  next_idx;
    logic [31:0] pat_in_ext;
    logic [31:0] pat_q_ext;
    logic        start_bit;
    logic        next_bit;
    logic        first_bit;

    // Widening to 32 bits keeps every dynamic index in range for any legal PAT_W
    always_comb begin
        len_eff    = ((len == 6'd0) || (len > PAT_LEN)) ? PAT_LEN : len;
        next_idx   = bit_idx + 6'd1;
        pat_in_ext = 32'(pattern);
        pat_q_ext  = 32'(pat_q);
        start_bit  = pat_in_ext[5'(len_eff - 6'd1)];
        next_bit   = pat_q_ext[5'(len_q - 6'd1 - next_idx)];
        first_bit  = pat_q_ext[5'(len_q - 6'd1)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            seq_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            seq_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                    bit_idx   <= '0;
                    if (start) begin
                        state     <= SHIFT;
                        pat_q     <= pattern;
                        len_q     <= len_eff;
                        loop_q    <= mode_loop;
                        div_cnt   <= '0;
                        seq_out   <= start_bit;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    bit_valid <= 1'b0;
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        if (bit_idx != len_q - 6'd1) begin
                            bit_idx   <= next_idx;
                            seq_out   <= next_bit;
                            bit_valid <= 1'b1;
                        end else if (loop_q) begin
                            bit_idx   <= '0;
                            seq_out   <= first_bit;
                            bit_valid <= 1'b1;
                        end else begin
                            state   <= DONE;
                            bit_idx <= '0;
                            seq_out <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Upstream stimulus stage for the serial sequence detector. It latches a parallel test pattern and shifts it out MSB-first on `seq_out`, one bit per programmable bit period. Output is either one-shot or continuous loop, with start/stop control and busy/done status. `seq_out` drives the detector's serial input directly. `bit_valid` marks each new bit, so the downstream shift stage can be clock-enabled at the bit rate.

## Interface
- `CLK_DIV`, default 4: clock cycles per output bit. Legal range ≥ 1. 1 gives one bit per clock.
- `PAT_W`, default 16: pattern register width. Legal range 1..32.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: level, sampled only in IDLE. Begins a transfer.
- `stop` input, 1 bit: synchronous abort. Returns to IDLE from any state.
- `mode_loop` input, 1 bit: latched at start. 1 = repeat pattern until stopped. 0 = one-shot.
- `pattern` input, PAT_W bits: parallel pattern, latched at start.
- `len` input, 6 bits: number of bits to send, latched at start. 0 or > PAT_W means PAT_W.
- `seq_out` output, 1 bit: serial data, registered.
- `bit_valid` output, 1 bit: one-cycle pulse in the first cycle each new bit is on `seq_out`.
- `bit_idx` output, 6 bits: index (0-based) of the bit currently on `seq_out`. 0 in IDLE.
- `busy` output, 1 bit: high while in SHIFT.
- `done` output, 1 bit: one-cycle pulse when a one-shot transfer completes.

## Operation
- States: IDLE, SHIFT, DONE.
- **Reset values:** state = IDLE. All outputs are 0. Latched pattern, latched length and counters are all cleared.
- **IDLE → SHIFT** when `start`=1 and `stop`=0 at a clock edge. At that same edge:
  - latch `pattern`, the effective length N, and `mode_loop`;
  - set `div_cnt` to 0 and `bit_idx` to 0;
  - drive `seq_out` = `pattern[N-1]`, set `bit_valid`=1, set `busy`=1.
- **SHIFT:**
  - `div_cnt` increments every cycle. When `div_cnt` = CLK_DIV-1 it is a bit-end tick, and `div_cnt` wraps to 0.
  - On a tick with `bit_idx` < N-1: `bit_idx`++, `seq_out` = latched `pattern[N-1-bit_idx_new]`, `bit_valid`=1.
  - On a tick with `bit_idx` = N-1 and loop=1: `bit_idx`=0, `seq_out` = `pattern[N-1]`, `bit_valid`=1. The pattern is reloaded from the latched copy, not from the `pattern` input.
  - On a tick with `bit_idx` = N-1 and loop=0: go to DONE. `seq_out`=0, `busy`=0, `done`=1.
- **DONE → IDLE** unconditionally after one cycle. `done` returns to 0.
- **`start` outside IDLE** is ignored. Changes on `pattern`, `len` or `mode_loop` while busy have no effect.
- **`stop`=1 in any state:** next state is IDLE. `seq_out`, `bit_valid`, `busy`, `done` and `bit_idx` all go to 0, and no `done` pulse is produced. `stop` takes priority over `start` and over a simultaneous tick.
- **Back-to-back transfers:** `start` held high through DONE restarts from IDLE. The earliest restart edge is the edge after DONE.
- **Reset mid-transfer:** all outputs are immediately 0, the state is IDLE, and the latched data is discarded.
- **Counter widths:**
  - `div_cnt` is max($clog2(CLK_DIV),1) bits.
  - `bit_idx` is 6 bits. Its maximum value is N-1 ≤ 31, so it never wraps.

## Timing
- **Latency:** let E0 be the edge where `start` is accepted. The first bit is visible immediately after E0, so there is zero cycles of latency from acceptance.
- **Bit windows:** bit i is on `seq_out` for exactly CLK_DIV cycles, from E0+i·CLK_DIV to E0+(i+1)·CLK_DIV.
- **`bit_valid`** is high for exactly the first cycle of each bit. With CLK_DIV=1 it is high continuously while SHIFT is active.
- **One-shot completion:** `busy` falls and `done` pulses after edge E0+N·CLK_DIV. Total `busy` time is N·CLK_DIV cycles.
- **Loop mode:** there is no gap between the last bit of one pass and the first bit of the next.
- **Output behaviour:** all outputs are registered, with no combinational path from any input to any output. A `stop` asserted before edge Es clears the outputs after Es.

## Test plan
- **One-shot:** CLK_DIV=4, `pattern`=16'h0016, `len`=5, `mode_loop`=0, `start` pulsed → `seq_out` = 1,0,1,1,0, each held 4 cycles. `bit_valid` pulses at E0, +4, +8, +12, +16. `done`=1 in cycle E0+20. `busy` is high for exactly 20 cycles.
- **Loop and stop:** same pattern with `mode_loop`=1 → the sequence repeats as 10110 10110 … with no gap. `stop` at E0+27 → all outputs are 0 after the next edge, and `done` never pulses.
- **Default length:** `len`=0, `pattern`=16'hA5C3, CLK_DIV=1 → 16 consecutive bits 1010010111000011. `done` pulses at E0+16.
- **Ignored inputs while busy:** during SHIFT, pulse `start` and change `pattern` to 16'hFFFF → the output stream is unchanged and no restart occurs.
- **Reset mid-transfer:** assert `rst` mid-bit at bit_idx=2 → `seq_out`, `busy`, `bit_valid`, `done` and `bit_idx` are all 0 asynchronously. After release, a new `start` sends from bit 0.
- **Detector chain:** CLK_DIV=1, `pattern`=5'b10110 looped, feeding the detector with compare value 5'b10110 → the detector's equal flag asserts every 5 cycles once its shift register is filled.
